// File: rtl/xbus_pkg.sv
// xbus_pkg -- shared XBUS definitions.
//   XBUS_NSLAVES        : number of chip-select lines driven by the decoder
//   state_e             : initiator state encoding (IDLE/BUS/RESP)
//   SLV_BASE/SLV_LIMIT  : slave address map, inclusive byte ranges
//   xbus_decode()       : address -> one-hot chip-select, shared with the decoder
package xbus_pkg;

  localparam int XBUS_NSLAVES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] SLV_BASE  [XBUS_NSLAVES] = '{
    32'h0000_0000, 32'h8000_0000, 32'h9000_0000, 32'hA000_0000
  };
  localparam logic [31:0] SLV_LIMIT [XBUS_NSLAVES] = '{
    32'h0000_FFFF, 32'h8000_FFFF, 32'h9000_FFFF, 32'hAFFF_FFFF
  };

  function automatic logic [XBUS_NSLAVES-1:0] xbus_decode(input logic [31:0] addr);
    logic [XBUS_NSLAVES-1:0] cs;
    cs = '0;
    for (int i = 0; i < XBUS_NSLAVES; i++) begin
      cs[i] = (addr >= SLV_BASE[i]) && (addr <= SLV_LIMIT[i]);
    end
    return cs;
  endfunction

endpackage

// File: rtl/xbus_watchdog.sv
// xbus_watchdog -- BUS-state cycle counter with expiry flag.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count (asserted when a transaction is accepted)
//   inc      : one BUS cycle elapsed without acknowledge
//   expired  : this cycle's increment brings the count to TIMEOUT
module xbus_watchdog
  import xbus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The transaction leaves BUS on expiry, so the count never wraps.
  assign expired = inc && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/xbus_master.sv
// xbus_master -- single-outstanding XBUS initiator.
// Bridges a core load/store request onto XBUS, reports decode misses seen on
// the decoder chip-selects, waits for slave ack and returns data/error.
// Optional build macro: XBUS_TIMEOUT_EN adds an ack watchdog (xbus_watchdog).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/ready/we/addr/wdata/be : core request (held by core until ready)
//   resp_valid/rdata/err          : one-cycle response strobe, no backpressure
//   xbus_as/addr/wdata/we/be      : bus request, stable throughout BUS
//   xbus_cs                       : decoder chip-selects (all-zero = miss)
//   xbus_rdata, xbus_ack          : muxed slave read data / acknowledge
module xbus_master
  import xbus_pkg::*;
#(
  parameter int NSLAVES = XBUS_NSLAVES,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_be,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic               xbus_as,
  output logic [31:0]        xbus_addr,
  output logic [31:0]        xbus_wdata,
  output logic               xbus_we,
  output logic [3:0]         xbus_be,
  input  logic [NSLAVES-1:0] xbus_cs,
  input  logic [31:0]        xbus_rdata,
  input  logic               xbus_ack
);

  state_e state, state_nxt;
  logic   load_req;
  logic   done;
  logic   done_err;
  logic   wd_expired;

`ifdef XBUS_TIMEOUT_EN
  xbus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (load_req),
    .inc     ((state == BUS) && !xbus_ack),
    .expired (wd_expired)
  );
  logic unused_bits;
  assign unused_bits = ^req_addr[1:0];
`else
  assign wd_expired = 1'b0;
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_bits;
  assign unused_bits = ^req_addr[1:0] ^ (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes come straight from the state so reset drops xbus_as immediately.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    xbus_as    = 1'b0;
    resp_valid = 1'b0;
    load_req   = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_req  = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        xbus_as = 1'b1;
        // Miss beats ack, ack beats timeout.
        if (xbus_cs == '0) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (xbus_ack) begin
          done = 1'b1;
        end else if (wd_expired) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
        if (done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xbus_addr  <= '0;
      xbus_wdata <= '0;
      xbus_we    <= 1'b0;
      xbus_be    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (load_req) begin
        xbus_addr  <= {req_addr[31:2], 2'b00};
        xbus_wdata <= req_wdata;
        xbus_we    <= req_we;
        xbus_be    <= req_be;
      end
      if (done) begin
        resp_err   <= done_err;
        resp_rdata <= (done_err || xbus_we) ? 32'h0 : xbus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_xbus_master.sv
// tb_xbus_master -- directed bench for xbus_master.
// The decoder is modelled from the shared package map; slave ack/data are
// driven directly by the stimulus sequence.
module tb_xbus_master;
  import xbus_pkg::*;

  localparam int NS = XBUS_NSLAVES;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [31:0]   req_addr, req_wdata;
  logic [3:0]    req_be;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          xbus_as, xbus_we;
  logic [31:0]   xbus_addr, xbus_wdata, xbus_rdata;
  logic [3:0]    xbus_be;
  logic [NS-1:0] xbus_cs;
  logic          xbus_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign xbus_cs = xbus_as ? xbus_decode(xbus_addr) : '0;

  xbus_master #(
    .NSLAVES (NS),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .xbus_as    (xbus_as),
    .xbus_addr  (xbus_addr),
    .xbus_wdata (xbus_wdata),
    .xbus_we    (xbus_we),
    .xbus_be    (xbus_be),
    .xbus_cs    (xbus_cs),
    .xbus_rdata (xbus_rdata),
    .xbus_ack   (xbus_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  initial begin
    int as_cycles;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    xbus_rdata = '0; xbus_ack = 1'b0;
    tick(); tick();

    chk("rst_ready", req_ready, 1);
    chk("rst_as", xbus_as, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_addr", xbus_addr, 0);
    chk("rst_wdata", xbus_wdata, 0);
    chk("rst_we", xbus_we, 0);
    chk("rst_be", xbus_be, 0);
    rst = 1'b0;
    tick();

    // Read, ack in first BUS cycle
    issue(1'b0, 32'h8000_0010, 32'h0, 4'hF);
    chk("rd_ready_c0", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("rd_as_c1", xbus_as, 1);
    chk("rd_addr_c1", xbus_addr, 32'h8000_0010);
    chk("rd_we_c1", xbus_we, 0);
    chk("rd_be_c1", xbus_be, 4'hF);
    chk("rd_ready_c1", req_ready, 0);
    chk("rd_resp_valid_c1", resp_valid, 0);
    xbus_ack = 1'b1; xbus_rdata = 32'hDEAD_BEEF;
    tick();
    xbus_ack = 1'b0; xbus_rdata = '0;
    chk("rd_as_c2", xbus_as, 0);
    chk("rd_resp_valid_c2", resp_valid, 1);
    chk("rd_rdata_c2", resp_rdata, 32'hDEAD_BEEF);
    chk("rd_err_c2", resp_err, 0);
    tick();
    chk("rd_resp_valid_c3", resp_valid, 0);
    chk("rd_ready_c3", req_ready, 1);

    // Write with 3 wait states; low address bits dropped
    issue(1'b1, 32'h0000_1006, 32'h1234_5678, 4'b0011);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("wr_as", xbus_as, 1);
      chk("wr_we", xbus_we, 1);
      chk("wr_be", xbus_be, 4'b0011);
      chk("wr_wdata", xbus_wdata, 32'h1234_5678);
      chk("wr_addr", xbus_addr, 32'h0000_1004);
      chk("wr_resp_valid", resp_valid, 0);
      if (c == 4) begin
        xbus_ack = 1'b1; xbus_rdata = 32'hFFFF_FFFF;
      end
      tick();
    end
    xbus_ack = 1'b0; xbus_rdata = '0;
    chk("wr_resp_valid", resp_valid, 1);
    chk("wr_rdata", resp_rdata, 0);
    chk("wr_err", resp_err, 0);
    chk("wr_as_resp", xbus_as, 0);
    tick();

    // Decode miss, with a stray ack in the same cycle that must be ignored
    issue(1'b0, 32'h4000_0000, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    chk("miss_as_c1", xbus_as, 1);
    xbus_ack = 1'b1; xbus_rdata = 32'hAAAA_5555;
    tick();
    xbus_ack = 1'b0; xbus_rdata = '0;
    chk("miss_as_c2", xbus_as, 0);
    chk("miss_resp_valid", resp_valid, 1);
    chk("miss_err", resp_err, 1);
    chk("miss_rdata", resp_rdata, 0);
    tick();
    chk("miss_ready_c3", req_ready, 1);

    // Back-to-back reads, req_valid held high
    issue(1'b0, 32'h9000_0020, 32'h0, 4'hF);
    tick();
    req_addr = 32'hA000_0004;
    chk("b2b_ready_c1", req_ready, 0);
    chk("b2b_addr_c1", xbus_addr, 32'h9000_0020);
    xbus_ack = 1'b1; xbus_rdata = 32'h1111_1111;
    tick();
    xbus_ack = 1'b0; xbus_rdata = '0;
    chk("b2b_ready_c2", req_ready, 0);
    chk("b2b_resp1", resp_rdata, 32'h1111_1111);
    chk("b2b_valid_c2", resp_valid, 1);
    tick();
    chk("b2b_ready_c3", req_ready, 1);
    chk("b2b_as_c3", xbus_as, 0);
    tick();
    req_valid = 1'b0;
    chk("b2b_as_c4", xbus_as, 1);
    chk("b2b_addr_c4", xbus_addr, 32'hA000_0004);
    xbus_ack = 1'b1; xbus_rdata = 32'h2222_2222;
    tick();
    xbus_ack = 1'b0; xbus_rdata = '0;
    chk("b2b_valid_c5", resp_valid, 1);
    chk("b2b_resp2", resp_rdata, 32'h2222_2222);
    tick();

    // Reset in the middle of BUS
    issue(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    chk("mrst_as_before", xbus_as, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_as_async", xbus_as, 0);
    chk("mrst_ready_async", req_ready, 1);
    chk("mrst_valid_async", resp_valid, 0);
    tick();
    rst = 1'b0;
    xbus_ack = 1'b1; xbus_rdata = 32'h5A5A_5A5A;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mrst_no_resp", resp_valid, 0);
      chk("mrst_no_as", xbus_as, 0);
    end
    xbus_ack = 1'b0; xbus_rdata = '0;
    chk("mrst_rdata", resp_rdata, 0);
    tick();

    // No ack at all
    issue(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
`ifdef XBUS_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      chk("to_as", xbus_as, 1);
      chk("to_valid", resp_valid, 0);
      tick();
    end
    chk("to_as_end", xbus_as, 0);
    chk("to_valid_end", resp_valid, 1);
    chk("to_err", resp_err, 1);
    chk("to_rdata", resp_rdata, 0);
    tick();
`else
    as_cycles = 0;
    for (int c = 0; c < 1100; c++) begin
      if (xbus_as === 1'b1 && resp_valid === 1'b0) as_cycles++;
      tick();
    end
    chk("noto_as_cycles", as_cycles, 1100);
    chk("noto_as_still", xbus_as, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xbus_master.md
Name: xbus_master

Overview:
- Single-outstanding XBUS initiator that bridges a core-side load/store request port onto the shared XBUS.
- Drives xbus_as/xbus_addr toward the address decoder and slaves, monitors the decoder's chip-selects for decode misses, and waits for slave acknowledge.
- Returns read data or an error to the core.
- Sits between the CPU LSU and the XBUS fabric (decoder + slave mux).

Parameters:
- NSLAVES, 4, number of chip-select lines produced by the address decoder.
- TIMEOUT, 255, max BUS-state cycles without ack before abort (used only with XBUS_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  master can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_be  input  4  byte-lane enables.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  decode miss or timeout; qualified by resp_valid.
- xbus_as  output  1  address strobe / transaction active.
- xbus_addr  output  32  word address; bits [1:0] forced to 0.
- xbus_wdata  output  32  write data.
- xbus_we  output  1  write enable.
- xbus_be  output  4  byte enables.
- xbus_cs  input  NSLAVES  chip-selects from the address decoder; combinational on xbus_as/xbus_addr.
- xbus_rdata  input  32  muxed slave read data.
- xbus_ack  input  1  muxed slave acknowledge.

Behaviour:
- State machine: IDLE, BUS, RESP.
- Reset (async, immediate):
  - state = IDLE.
  - req_ready = 1.
  - xbus_as, xbus_we, resp_valid, resp_err = 0.
  - xbus_addr, xbus_wdata, xbus_be, resp_rdata = 0.
- IDLE:
  - req_ready = 1; xbus_as = 0.
  - On req_valid && req_ready, latch we/addr/wdata/be and go to BUS.
- BUS:
  - req_ready = 0; xbus_as = 1.
  - xbus_* driven from the latched registers, held stable for the whole state.
  - Each cycle, evaluated in priority order:
    - (1) xbus_cs == 0 (decode miss): resp_err <= 1, resp_rdata <= 0, go to RESP.
    - (2) xbus_ack: resp_err <= 0; resp_rdata <= xbus_rdata for reads, 0 for writes; go to RESP.
    - (3) Otherwise stay in BUS.
  - A decode miss is therefore reported in the first BUS cycle.
- RESP:
  - resp_valid = 1 for exactly one cycle, then go to IDLE.
  - xbus_as = 0 in RESP.
  - The core side has no backpressure and must sink the response.
- Latency (request accepted in cycle 0):
  - xbus_as high in cycle 1.
  - Ack in cycle 1 gives resp_valid in cycle 2.
  - Next request can be accepted in cycle 3.
  - Each extra wait state adds one cycle.
- Simultaneous events:
  - ack arriving with cs == 0 is treated as a miss; ack is ignored.
  - ack outside BUS is ignored.
  - req_valid is ignored outside IDLE; the request must be held by the core.
- Reset mid-transaction: xbus_as drops asynchronously, the in-flight response is discarded, and no resp_valid is produced.
- req_addr[1:0] is discarded; lane selection is carried only by xbus_be.

Optional Feature:
- Macro: XBUS_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT with no ack and no miss, the transaction ends: resp_err <= 1, resp_rdata <= 0, go to RESP.
  - A decode miss or ack in the same cycle as the timeout takes precedence.
  - Counter width is clog2(TIMEOUT+1).
- Undefined: no counter exists; BUS waits indefinitely for ack.

Decomposition:
- Package xbus_pkg holds:
  - NSLAVES.
  - The state enum (IDLE/BUS/RESP).
  - Slave address-map constants (base and limit per slave), shared with the decoder.
- Natural sub-module: xbus_watchdog (counter plus expiry flag), instantiated only under XBUS_TIMEOUT_EN.

Test Plan:
- Read 0x80000010, slave acks on the first BUS cycle with 0xDEADBEEF -> xbus_as high in cycle 1 only; resp_valid in cycle 2; resp_rdata = 0xDEADBEEF; resp_err = 0.
- Write 0x00001004, data 0x12345678, be = 4'b0011, ack after 3 wait cycles -> xbus_we = 1, xbus_be = 0011, xbus_wdata stable for 4 cycles; resp_valid = 1; resp_rdata = 0.
- Read 0x40000000 (xbus_cs = 0) -> exactly one BUS cycle; resp_err = 1 in the next cycle; no slave access.
- Back-to-back reads with req_valid held high -> second accept in cycle 3; req_ready = 0 in cycles 1–2.
- Assert rst while in BUS with no ack -> xbus_as = 0 in the same cycle; req_ready = 1; no resp_valid afterwards.
- With XBUS_TIMEOUT_EN, TIMEOUT = 8, no ack -> resp_err = 1 after 8 BUS cycles. Without the macro -> xbus_as stays high for more than 1000 cycles.
